// File: rtl/word_serializer.sv
// Word serializer: an 18-bit-wide FIFO feeding a UART-style framer
// (start, 16 data bits LSB first, parity, stop) with an idle gap after each message.
//
// state | meaning
// IDLE  | line high, waiting for a queued word
// SHIFT | frame bits on SDO, BIT_DIV cycles per bit
// GAP   | line high after the last word of a message

module word_serializer #(
  parameter int BIT_DIV     = 4,
  parameter int FIFO_AW     = 4,
  parameter int BUSY_THRESH = 14,
  parameter int GAP_BITS    = 2
) (
  input  logic        CLK,
  input  logic        RST,
  input  logic        ENA,
  input  logic [15:0] DATA_IN,
  input  logic [7:0]  PAYLOAD_LEN,
  input  logic        PARITY_IN,
  output logic        SDO,
  output logic        SERIALIZER_BUSY,
  output logic        MSG_DONE,
  output logic        OVERFLOW
);

  localparam int DEPTH   = 1 << FIFO_AW;
  localparam int FW      = FIFO_AW + 1;
  localparam int GAP_CYC = GAP_BITS * BIT_DIV;
  localparam int TW      = $clog2((GAP_CYC > BIT_DIV) ? GAP_CYC : BIT_DIV) + 1;

  typedef enum logic [1:0] {IDLE, SHIFT, GAP} state_t;

  logic [17:0]        mem [DEPTH];
  logic [17:0]        head;
  logic [FIFO_AW-1:0] wr_ptr, rd_ptr;
  logic [FW-1:0]      fill, fill_nxt;
  logic               full, empty, push, pop;
  logic [7:0]         in_cnt, len_q, len_eff;
  logic               par_q, par_eff, in_last;

  state_t             state_q, state_nxt;
  logic [TW-1:0]      tmr_q, tmr_nxt;
  logic [4:0]         idx_q, idx_nxt;
  logic [17:0]        shreg_q, shreg_nxt;
  logic               last_q, last_nxt;
  logic               sdo_nxt, done_nxt, load;

  assign full     = (fill == FW'(DEPTH));
  assign empty    = (fill == '0);
  assign push     = ENA && !full;
  assign head     = mem[rd_ptr];
  assign fill_nxt = fill + FW'(push) - FW'(pop);

  // The first word of a message uses the live length/parity; later words use the latched copy.
  assign len_eff = (in_cnt == 8'd0) ? PAYLOAD_LEN : len_q;
  assign par_eff = (in_cnt == 8'd0) ? PARITY_IN : par_q;
  assign in_last = (in_cnt == len_eff - 8'd1);

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      in_cnt          <= 8'd0;
      len_q           <= 8'd0;
      par_q           <= 1'b0;
      wr_ptr          <= '0;
      rd_ptr          <= '0;
      fill            <= '0;
      OVERFLOW        <= 1'b0;
      SERIALIZER_BUSY <= 1'b0;
    end else begin
      if (ENA) begin
        in_cnt <= in_last ? 8'd0 : in_cnt + 8'd1;
        if (in_cnt == 8'd0) begin
          len_q <= PAYLOAD_LEN;
          par_q <= PARITY_IN;
        end
        if (full) OVERFLOW <= 1'b1;
      end
      if (push) wr_ptr <= wr_ptr + FIFO_AW'(1);
      if (pop)  rd_ptr <= rd_ptr + FIFO_AW'(1);
      fill            <= fill_nxt;
      SERIALIZER_BUSY <= (fill_nxt >= FW'(BUSY_THRESH));
    end
  end

  always_ff @(posedge CLK) begin
    if (push) mem[wr_ptr] <= {in_last, par_eff, DATA_IN};
  end

  always_ff @(posedge CLK or negedge RST) begin
    if (!RST) begin
      state_q  <= IDLE;
      tmr_q    <= '0;
      idx_q    <= 5'd0;
      shreg_q  <= 18'd0;
      last_q   <= 1'b0;
      SDO      <= 1'b1;
      MSG_DONE <= 1'b0;
    end else begin
      state_q  <= state_nxt;
      tmr_q    <= tmr_nxt;
      idx_q    <= idx_nxt;
      shreg_q  <= shreg_nxt;
      last_q   <= last_nxt;
      SDO      <= sdo_nxt;
      MSG_DONE <= done_nxt;
    end
  end

  always_comb begin
    state_nxt = state_q;
    tmr_nxt   = tmr_q;
    idx_nxt   = idx_q;
    shreg_nxt = shreg_q;
    last_nxt  = last_q;
    sdo_nxt   = SDO;
    done_nxt  = 1'b0;
    load      = 1'b0;
    pop       = 1'b0;
    case (state_q)
      IDLE: begin
        sdo_nxt = 1'b1;
        if (!empty) load = 1'b1;
      end
      SHIFT: begin
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TW'(1);
        end else if (idx_q != 5'd18) begin
          idx_nxt   = idx_q + 5'd1;
          sdo_nxt   = shreg_q[0];
          shreg_nxt = {1'b0, shreg_q[17:1]};
          tmr_nxt   = TW'(BIT_DIV - 1);
        end else if (last_q) begin
          state_nxt = GAP;
          sdo_nxt   = 1'b1;
          tmr_nxt   = TW'(GAP_CYC - 1);
        end else if (!empty) begin
          load = 1'b1;
        end else begin
          state_nxt = IDLE;
          sdo_nxt   = 1'b1;
        end
      end
      GAP: begin
        sdo_nxt = 1'b1;
        if (tmr_q != '0) begin
          tmr_nxt = tmr_q - TW'(1);
        end else begin
          state_nxt = IDLE;
          done_nxt  = 1'b1;
        end
      end
      default: begin
        state_nxt = IDLE;
        sdo_nxt   = 1'b1;
      end
    endcase
    // Start bit goes out directly; the shift register holds data, parity, stop.
    if (load) begin
      pop       = 1'b1;
      state_nxt = SHIFT;
      sdo_nxt   = 1'b0;
      idx_nxt   = 5'd0;
      tmr_nxt   = TW'(BIT_DIV - 1);
      last_nxt  = head[17];
      shreg_nxt = {1'b1, (^head[15:0]) ^ head[16], head[15:0]};
    end
  end

endmodule

// File: tb/tb_word_serializer.sv
// Bench for word_serializer: per-scenario tasks compare the recorded SDO/MSG_DONE
// waveform against one built from the framing rules (start, data LSB first, parity, stop, gap).

module tb_word_serializer;
  localparam int BIT_DIV     = 4;
  localparam int FIFO_AW     = 4;
  localparam int BUSY_THRESH = 14;
  localparam int GAP_BITS    = 2;
  localparam int DEPTH       = 1 << FIFO_AW;
  localparam int FRAME_CYC   = 19 * BIT_DIV;
  localparam int GAP_CYC     = GAP_BITS * BIT_DIV;

  logic        CLK = 1'b0;
  logic        RST = 1'b0;
  logic        ENA = 1'b0;
  logic [15:0] DATA_IN = 16'd0;
  logic [7:0]  PAYLOAD_LEN = 8'd0;
  logic        PARITY_IN = 1'b0;
  logic        SDO, SERIALIZER_BUSY, MSG_DONE, OVERFLOW;

  int n_tests = 0;
  int n_fail  = 0;

  bit          stim_ena[$];
  logic [15:0] stim_data[$];
  logic [7:0]  stim_len[$];
  bit          stim_par[$];
  bit          exp_sdo[$];
  bit          exp_done[$];
  logic        obs_sdo[$];
  logic        obs_done[$];
  logic        obs_busy[$];
  logic        obs_ovf[$];

  always #5 CLK = ~CLK;

  word_serializer #(
    .BIT_DIV(BIT_DIV), .FIFO_AW(FIFO_AW), .BUSY_THRESH(BUSY_THRESH), .GAP_BITS(GAP_BITS)
  ) dut (
    .CLK(CLK), .RST(RST), .ENA(ENA), .DATA_IN(DATA_IN), .PAYLOAD_LEN(PAYLOAD_LEN),
    .PARITY_IN(PARITY_IN), .SDO(SDO), .SERIALIZER_BUSY(SERIALIZER_BUSY),
    .MSG_DONE(MSG_DONE), .OVERFLOW(OVERFLOW)
  );

  function automatic void clear_all();
    stim_ena.delete(); stim_data.delete(); stim_len.delete(); stim_par.delete();
    exp_sdo.delete(); exp_done.delete();
    obs_sdo.delete(); obs_done.delete(); obs_busy.delete(); obs_ovf.delete();
  endfunction

  function automatic void add_strobe(input logic [15:0] w, input logic [7:0] len, input bit par);
    stim_ena.push_back(1'b1); stim_data.push_back(w);
    stim_len.push_back(len);  stim_par.push_back(par);
  endfunction

  function automatic void add_quiet(input int n);
    for (int i = 0; i < n; i++) begin
      stim_ena.push_back(1'b0); stim_data.push_back(16'($urandom));
      stim_len.push_back(8'($urandom)); stim_par.push_back(1'($urandom));
    end
  endfunction

  function automatic void add_level(input bit lvl, input bit done, input int n);
    for (int i = 0; i < n; i++) begin
      exp_sdo.push_back(lvl); exp_done.push_back(done);
    end
  endfunction

  // One frame on the line: start 0, data LSB first, parity (even = XOR of data), stop 1.
  function automatic void add_frame(input logic [15:0] w, input bit odd);
    logic [18:0] fr;
    fr = {1'b1, (^w) ^ odd, w, 1'b0};
    for (int b = 0; b < 19; b++) add_level(fr[b], 1'b0, BIT_DIV);
  endfunction

  function automatic void add_msg_end();
    add_level(1'b1, 1'b0, GAP_CYC);
    add_level(1'b1, 1'b1, 1);
  endfunction

  // Samples outputs at each falling edge, then drives that cycle's stimulus.
  task automatic run(input int n);
    for (int i = 0; i < n; i++) begin
      @(negedge CLK);
      obs_sdo.push_back(SDO); obs_done.push_back(MSG_DONE);
      obs_busy.push_back(SERIALIZER_BUSY); obs_ovf.push_back(OVERFLOW);
      if (i < stim_ena.size()) begin
        ENA = stim_ena[i]; DATA_IN = stim_data[i];
        PAYLOAD_LEN = stim_len[i]; PARITY_IN = stim_par[i];
      end else begin
        ENA = 1'b0;
      end
    end
    ENA = 1'b0;
  endtask

  task automatic do_reset();
    @(negedge CLK);
    RST = 1'b0; ENA = 1'b0;
    repeat (2) @(negedge CLK);
    RST = 1'b1;
  endtask

  task automatic test_reset();
    @(negedge CLK);
    RST = 1'b0;
    #1;
    n_tests++; if (SDO !== 1'b1) begin n_fail++; $display("FAIL reset_sdo: got %b want 1", SDO); end
    n_tests++; if (SERIALIZER_BUSY !== 1'b0) begin n_fail++; $display("FAIL reset_busy: got %b want 0", SERIALIZER_BUSY); end
    n_tests++; if (MSG_DONE !== 1'b0) begin n_fail++; $display("FAIL reset_done: got %b want 0", MSG_DONE); end
    n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL reset_ovf: got %b want 0", OVERFLOW); end
    @(negedge CLK);
    RST = 1'b1;
    @(negedge CLK);
    n_tests++; if (SDO !== 1'b1) begin n_fail++; $display("FAIL reset_idle_sdo: got %b want 1", SDO); end
  endtask

  task automatic test_single_word();
    int mism, first;
    do_reset();
    clear_all();
    add_strobe(16'h0001, 8'd1, 1'b0);
    add_level(1'b1, 1'b0, 2);
    add_frame(16'h0001, 1'b0);
    add_msg_end();
    add_level(1'b1, 1'b0, 3);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL single_word_stream: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
    // 0x0001 has one set bit, so the even-parity bit is 1.
    n_tests++;
    if (obs_sdo[2 + 17*BIT_DIV] !== 1'b1) begin
      n_fail++; $display("FAIL single_word_parity: got %b want 1", obs_sdo[2 + 17*BIT_DIV]);
    end
  endtask

  task automatic test_back_to_back();
    int mism, first;
    logic [15:0] w [3];
    w[0] = 16'hA5A5; w[1] = 16'hFFFF; w[2] = 16'h0000;
    do_reset();
    clear_all();
    add_strobe(w[0], 8'd3, 1'b1);
    add_strobe(w[1], 8'd7, 1'b0);
    add_strobe(w[2], 8'd1, 1'b0);
    add_level(1'b1, 1'b0, 2);
    for (int k = 0; k < 3; k++) add_frame(w[k], 1'b1);
    add_msg_end();
    add_level(1'b1, 1'b0, 3);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL back_to_back_stream: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
  endtask

  // Consecutive random messages without reset; later words carry junk length/parity.
  task automatic test_random_messages();
    int mism, first, len;
    bit par;
    logic [15:0] w;
    for (int m = 0; m < 4; m++) begin
      clear_all();
      len = $urandom_range(1, 5);
      par = 1'($urandom);
      add_level(1'b1, 1'b0, 2);
      for (int k = 0; k < len; k++) begin
        w = 16'($urandom);
        if (k == 0) add_strobe(w, 8'(len), par);
        else        add_strobe(w, 8'($urandom), 1'($urandom));
        add_quiet($urandom_range(0, 2));
        add_frame(w, par);
      end
      add_msg_end();
      add_level(1'b1, 1'b0, 3);
      run(exp_sdo.size());
      mism = 0; first = -1;
      for (int i = 0; i < exp_sdo.size(); i++)
        if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
          if (first < 0) first = i;
          mism++;
        end
      n_tests++;
      if (mism != 0) begin
        n_fail++;
        $display("FAIL random_msg%0d_stream (len %0d par %0d): %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
                 m, len, par, mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
      end
    end
  endtask

  task automatic test_busy_overflow();
    int mism, first, acc, occ, drop_idx;
    logic [15:0] w;
    logic [15:0] kept[$];
    do_reset();
    clear_all();
    acc = 0; drop_idx = -1;
    // Word 0 moves into the framer at the end of cycle 1, freeing one slot.
    for (int i = 0; i < DEPTH + 2; i++) begin
      w = 16'($urandom);
      add_strobe(w, 8'd0, 1'b0);
      occ = acc - ((i >= 2) ? 1 : 0);
      if (occ < DEPTH) begin acc++; kept.push_back(w); end
      else if (drop_idx < 0) drop_idx = i;
    end
    add_level(1'b1, 1'b0, 2);
    foreach (kept[k]) add_frame(kept[k], 1'b0);
    add_level(1'b1, 1'b0, 4);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL overflow_stream: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
    // Fill seen at sample s (s >= 2) during the strobe burst is s-1.
    n_tests++; if (obs_busy[14] !== 1'b0) begin n_fail++; $display("FAIL busy_below_thresh: got %b want 0", obs_busy[14]); end
    n_tests++; if (obs_busy[16] !== 1'b1) begin n_fail++; $display("FAIL busy_at_thresh: got %b want 1", obs_busy[16]); end
    n_tests++; if (obs_busy[18] !== 1'b1) begin n_fail++; $display("FAIL busy_full: got %b want 1", obs_busy[18]); end
    n_tests++; if (obs_ovf[drop_idx] !== 1'b0) begin n_fail++; $display("FAIL ovf_before_drop: got %b want 0", obs_ovf[drop_idx]); end
    n_tests++; if (obs_ovf[drop_idx+1] !== 1'b1) begin n_fail++; $display("FAIL ovf_after_drop: got %b want 1", obs_ovf[drop_idx+1]); end
    n_tests++; if (obs_ovf[obs_ovf.size()-1] !== 1'b1) begin n_fail++; $display("FAIL ovf_sticky: got %b want 1", obs_ovf[obs_ovf.size()-1]); end
    do_reset();
    @(negedge CLK);
    n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ovf_cleared_by_reset: got %b want 0", OVERFLOW); end
  endtask

  // LEN=0 means 256 words; words arrive slightly faster than they drain.
  task automatic test_len256();
    int mism, first;
    bit par;
    logic [15:0] w;
    do_reset();
    clear_all();
    par = 1'($urandom);
    add_level(1'b1, 1'b0, 2);
    for (int k = 0; k < 256; k++) begin
      w = 16'($urandom);
      add_strobe(w, (k == 0) ? 8'd0 : 8'($urandom), (k == 0) ? par : 1'($urandom));
      add_quiet(FRAME_CYC - 3);
      add_frame(w, par);
    end
    add_msg_end();
    add_level(1'b1, 1'b0, 3);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL len256_stream: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
  endtask

  task automatic test_reset_midframe();
    int mism, first;
    logic [15:0] w;
    do_reset();
    clear_all();
    add_strobe(16'h0F0F, 8'd2, 1'b0);
    add_strobe(16'h1234, 8'd9, 1'b1);
    // Data bit 7 is frame bit 8, first seen at sample 2 + 8*BIT_DIV.
    run(2 + 8*BIT_DIV + 1);
    n_tests++; if (SDO !== 1'b0) begin n_fail++; $display("FAIL midframe_bit7: got %b want 0", SDO); end
    #2 RST = 1'b0;
    #1;
    n_tests++; if (SDO !== 1'b1) begin n_fail++; $display("FAIL midframe_reset_sdo: got %b want 1", SDO); end
    n_tests++; if (MSG_DONE !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_done: got %b want 0", MSG_DONE); end
    n_tests++; if (SERIALIZER_BUSY !== 1'b0) begin n_fail++; $display("FAIL midframe_reset_busy: got %b want 0", SERIALIZER_BUSY); end
    @(negedge CLK);
    RST = 1'b1;
    clear_all();
    add_level(1'b1, 1'b0, 2*FRAME_CYC);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL after_reset_quiet: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=1 done=0",
               mism, first, obs_sdo[first], obs_done[first]);
    end
    clear_all();
    w = 16'($urandom);
    add_strobe(w, 8'd1, 1'b1);
    add_level(1'b1, 1'b0, 2);
    add_frame(w, 1'b1);
    add_msg_end();
    add_level(1'b1, 1'b0, 3);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL after_reset_msg: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
  endtask

  // Frame k starts at sample 2 + k*FRAME_CYC, so its word is popped in the cycle before.
  task automatic test_ena_at_pop();
    int mism, first, pop1, pop2;
    logic [15:0] w;
    logic [15:0] words[$];
    do_reset();
    clear_all();
    pop1 = 1 + FRAME_CYC;
    pop2 = 1 + 2*FRAME_CYC;
    for (int i = 0; i < BUSY_THRESH + 1; i++) begin
      w = 16'($urandom); words.push_back(w); add_strobe(w, 8'd0, 1'b0);
    end
    add_quiet(pop1 - (BUSY_THRESH + 1));
    w = 16'($urandom); words.push_back(w); add_strobe(w, 8'd0, 1'b0);
    add_level(1'b1, 1'b0, 2);
    foreach (words[k]) add_frame(words[k], 1'b0);
    add_level(1'b1, 1'b0, 4);
    run(exp_sdo.size());
    mism = 0; first = -1;
    for (int i = 0; i < exp_sdo.size(); i++)
      if (obs_sdo[i] !== exp_sdo[i] || obs_done[i] !== exp_done[i]) begin
        if (first < 0) first = i;
        mism++;
      end
    n_tests++;
    if (mism != 0) begin
      n_fail++;
      $display("FAIL ena_at_pop_stream: %0d cycles differ, first at %0d: sdo=%b done=%b, expected sdo=%b done=%b",
               mism, first, obs_sdo[first], obs_done[first], exp_sdo[first], exp_done[first]);
    end
    n_tests++; if (obs_busy[pop1-1] !== 1'b1) begin n_fail++; $display("FAIL busy_before_pop: got %b want 1", obs_busy[pop1-1]); end
    n_tests++; if (obs_busy[pop1+1] !== 1'b1) begin n_fail++; $display("FAIL busy_after_pop_push: got %b want 1", obs_busy[pop1+1]); end
    n_tests++; if (obs_busy[pop1+10] !== 1'b1) begin n_fail++; $display("FAIL busy_hold: got %b want 1", obs_busy[pop1+10]); end
    n_tests++; if (obs_busy[pop2+5] !== 1'b0) begin n_fail++; $display("FAIL busy_after_next_pop: got %b want 0", obs_busy[pop2+5]); end
    n_tests++; if (OVERFLOW !== 1'b0) begin n_fail++; $display("FAIL ena_at_pop_ovf: got %b want 0", OVERFLOW); end
  endtask

  initial begin
    do_reset();
    test_reset();
    test_single_word();
    test_back_to_back();
    test_random_messages();
    test_busy_overflow();
    test_len256();
    test_reset_midframe();
    test_ena_at_pop();
    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/word_serializer.md
WORD_SERIALIZER -- requirements
Module: word_serializer

Interface
REQ-001 Parameter BIT_DIV, default 4: clock cycles per serial bit (>=2).
REQ-002 Parameter FIFO_AW, default 4: FIFO address width; depth = 2^FIFO_AW words.
REQ-003 Parameter BUSY_THRESH, default 14: fill level at or above which SERIALIZER_BUSY asserts.
REQ-004 Parameter GAP_BITS, default 2: idle bit-times inserted after each message.
REQ-005 CLK  input  1  single clock for all logic.
REQ-006 RST  input  1  asynchronous, active-low reset.
REQ-007 ENA  input  1  one-cycle strobe: DATA_IN holds a valid payload word.
REQ-008 DATA_IN  input  16  payload word from the slave-FIFO read path.
REQ-009 PAYLOAD_LEN  input  8  message length in words; sampled on the first word of a message.
REQ-010 PARITY_IN  input  1  parity mode, sampled with PAYLOAD_LEN: 0 = even, 1 = odd.
REQ-011 SDO  output  1  serial line, idle high, registered.
REQ-012 SERIALIZER_BUSY  output  1  back-pressure to the read path.
REQ-013 MSG_DONE  output  1  one-cycle pulse when a message and its gap finish.
REQ-014 OVERFLOW  output  1  sticky: a word was dropped.

Function
REQ-015 Input side SHALL write {last, parity_mode, DATA_IN} (18 bits) into the FIFO on each ENA while not full.
REQ-016 An 8-bit in_cnt SHALL count ENA strobes; when in_cnt==0, PAYLOAD_LEN and PARITY_IN SHALL be latched.
REQ-017 last SHALL equal (in_cnt == latched_len-1) with 8-bit wrap; PAYLOAD_LEN==0 means 256 words; in_cnt returns to 0 after the last word.
REQ-018 ENA while FIFO full: word dropped, OVERFLOW set until reset; in_cnt still advances.
REQ-019 SERIALIZER_BUSY SHALL equal (fill >= BUSY_THRESH), registered from fill.
REQ-020 Simultaneous ENA and pop: both occur, fill unchanged.
REQ-021 FSM states: IDLE, SHIFT, GAP.
REQ-022 IDLE: SDO=1; FIFO non-empty -> pop head, load frame, enter SHIFT.
REQ-023 Frame is 19 bits: start 0, DATA[0]..DATA[15] LSB first, parity, stop 1.
REQ-024 Parity bit: even mode = XOR of 16 data bits; odd mode = its inverse.
REQ-025 Each bit SHALL be held on SDO for exactly BIT_DIV cycles via a bit timer 0..BIT_DIV-1.
REQ-026 After the stop bit: last=0 with FIFO non-empty -> pop and start the next frame with no idle cycle; last=0 with FIFO empty -> IDLE; last=1 -> GAP.
REQ-027 GAP: SDO=1 for GAP_BITS*BIT_DIV cycles, then MSG_DONE pulses one cycle and the FSM enters IDLE.
REQ-028 Latency: ENA in cycle N into an empty FIFO with FSM in IDLE -> start bit on SDO from cycle N+2.

Reset
REQ-029 On RST low, asynchronously: state=IDLE, SDO=1, SERIALIZER_BUSY=0, MSG_DONE=0, OVERFLOW=0; FIFO pointers, fill, in_cnt, bit timer and bit index all 0.
REQ-030 Reset mid-frame SHALL abort the frame and discard FIFO contents; SDO SHALL be high in the first cycle after RST rises.

Verification
REQ-031 LEN=1, PARITY=0, word 16'h0001 -> SDO frame 0,1,0x15,1(parity),1, each bit 4 cycles, then 8 high cycles, then MSG_DONE pulse.
REQ-032 LEN=3, PARITY=1, words A5A5/FFFF/0000 back-to-back -> three contiguous frames, parity bits 1,1,1, one MSG_DONE after the third gap only.
REQ-033 16 ENA strobes with no drain time -> SERIALIZER_BUSY high once fill reaches 14; 17th strobe while full -> OVERFLOW=1 and the word is absent from SDO.
REQ-034 LEN=0 -> MSG_DONE only after the 256th frame.
REQ-035 RST pulsed during data bit 7 -> SDO=1, FIFO empty, no MSG_DONE; a new LEN=1 message then serializes correctly.
REQ-036 ENA coincident with a pop at fill=14 -> fill stays 14 and SERIALIZER_BUSY stays high.
